// File: rtl/wb_uart_fifo.sv
// wb_uart_fifo: Wishbone UART transmitter with TX FIFO, runtime baud divisor,
// configurable stop bits, sticky-overflow status word and idle interrupt.
module wb_uart_fifo #(
  parameter int unsigned CLK_DIV    = 862,
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned STOP_BITS  = 1
) (
  input  logic        clk,
  input  logic        rst,
  output logic        txd,
  output logic        irq,
  input  logic        cyc_i,
  input  logic        stb_i,
  input  logic        we_i,
  input  logic        adr_i,
  input  logic [31:0] dat_i,
  output logic [31:0] dat_o,
  output logic        ack_o
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned LW = AW + 1;
  localparam int unsigned DW = 16;
  localparam int unsigned SW = (STOP_BITS > 1) ? $clog2(STOP_BITS) : 1;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t          state, state_next;
  logic [DW-1:0]   div, cnt;
  logic            tick_c;
  logic [7:0]      mem [FIFO_DEPTH];
  logic [AW-1:0]   wptr, rptr;
  logic [LW-1:0]   level, level_next;
  logic            full_c, empty_c, busy_c;
  logic            push_c, pop_c, ovf_c;
  logic            overflow;
  logic            access_c, wr_data_c, rd_stat_c, wr_div_c;
  logic [31:0]     status_c;
  logic [7:0]      shift, shift_next;
  logic [2:0]      bit_idx, bit_idx_next;
  logic [SW-1:0]   stop_cnt, stop_cnt_next;
  logic            last_stop_c;
  logic            txd_next;
  logic            unused_c;

  assign unused_c = ^{dat_i[23:16], dat_i[7:0]};

  // Bus decode: one access per strobe, the ack cycle itself is the wait state.
  assign access_c  = cyc_i & stb_i & ~ack_o;
  assign wr_data_c = access_c &  we_i & ~adr_i;
  assign rd_stat_c = access_c & ~we_i & ~adr_i;
  assign wr_div_c  = access_c &  we_i &  adr_i;

  assign full_c  = (level == LW'(FIFO_DEPTH));
  assign empty_c = (level == '0);
  assign busy_c  = (state != IDLE);

  // A full FIFO still accepts a push when the transmitter pops in the same cycle.
  assign push_c = wr_data_c & (~full_c | pop_c);
  assign ovf_c  = wr_data_c & full_c & ~pop_c;

  assign status_c = {16'h0, 8'(level), 4'h0, overflow, empty_c, full_c, busy_c};

  // Divisor of 0 or 1 ticks every cycle.
  assign tick_c = (div <= DW'(1)) || (cnt == div - DW'(1));

  // Baud counter: wraps on tick, restarts whenever the divisor is rewritten.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (wr_div_c || tick_c) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + DW'(1);
    end
  end

  // Bus registers: ack, read data, divisor and sticky overflow.
  always_ff @(posedge clk) begin
    if (rst) begin
      ack_o    <= 1'b0;
      dat_o    <= '0;
      div      <= DW'(CLK_DIV);
      overflow <= 1'b0;
    end else begin
      ack_o <= access_c;
      if (wr_div_c) begin
        div <= dat_i[15:0];
      end
      if (access_c && !we_i) begin
        dat_o <= adr_i ? {16'h0, div} : status_c;
      end
      overflow <= ovf_c | (overflow & ~rd_stat_c);
    end
  end

  // FIFO storage; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (push_c) begin
      mem[wptr] <= dat_i[31:24];
    end
  end

  // FIFO occupancy after this cycle's push/pop.
  always_comb begin
    level_next = level;
    if (push_c && !pop_c) begin
      level_next = level + LW'(1);
    end else if (pop_c && !push_c) begin
      level_next = level - LW'(1);
    end
  end

  // FIFO pointers and level.
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      level <= '0;
    end else begin
      if (push_c) begin
        wptr <= wptr + AW'(1);
      end
      if (pop_c) begin
        rptr <= rptr + AW'(1);
      end
      level <= level_next;
    end
  end

  assign last_stop_c = (stop_cnt == SW'(STOP_BITS - 1));

  // TX state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // TX next-state: advances only on baud ticks.
  always_comb begin
    state_next = state;
    if (tick_c) begin
      case (state)
        IDLE:    if (!empty_c) state_next = START;
        START:   state_next = DATA;
        DATA:    if (bit_idx == 3'd7) state_next = STOP;
        STOP:    if (last_stop_c) state_next = empty_c ? IDLE : START;
        default: state_next = IDLE;
      endcase
    end
  end

  // TX outputs: pop request, next line level and shifter updates.
  always_comb begin
    pop_c         = 1'b0;
    txd_next      = txd;
    shift_next    = shift;
    bit_idx_next  = bit_idx;
    stop_cnt_next = stop_cnt;
    if (tick_c) begin
      case (state)
        IDLE: begin
          if (!empty_c) begin
            pop_c      = 1'b1;
            shift_next = mem[rptr];
            txd_next   = 1'b0;
          end
        end
        START: begin
          txd_next     = shift[0];
          bit_idx_next = 3'd0;
        end
        DATA: begin
          if (bit_idx == 3'd7) begin
            txd_next      = 1'b1;
            stop_cnt_next = '0;
          end else begin
            txd_next     = shift[1];
            shift_next   = {1'b0, shift[7:1]};
            bit_idx_next = bit_idx + 3'd1;
          end
        end
        STOP: begin
          if (last_stop_c) begin
            stop_cnt_next = '0;
            if (!empty_c) begin
              pop_c      = 1'b1;
              shift_next = mem[rptr];
              txd_next   = 1'b0;
            end else begin
              txd_next = 1'b1;
            end
          end else begin
            stop_cnt_next = stop_cnt + SW'(1);
          end
        end
        default: txd_next = 1'b1;
      endcase
    end
  end

  // TX datapath registers; line returns high immediately on reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      txd      <= 1'b1;
      shift    <= '0;
      bit_idx  <= '0;
      stop_cnt <= '0;
    end else begin
      txd      <= txd_next;
      shift    <= shift_next;
      bit_idx  <= bit_idx_next;
      stop_cnt <= stop_cnt_next;
    end
  end

  // Interrupt reflects the registered state: FIFO empty and transmitter idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      irq <= 1'b1;
    end else begin
      irq <= (state_next == IDLE) && (level_next == '0);
    end
  end

endmodule
